// File: rtl/gf2_parity_accumulator_if.sv
// Stream bundle for the GF(2) parity accumulator: product-vector input and parity-word output.
// The master side drives products and consumes parity; the slave side is the accumulator.
interface gf2_parity_accumulator_if #(
    parameter int unsigned P = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] in_prod;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_parity;
    logic         len_err;

    modport master (
        output in_valid,
        output in_prod,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_parity,
        input  len_err
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_parity,
        output len_err
    );
endinterface

// File: rtl/gf2_parity_accumulator.sv
// XOR-accumulates K product vectors per block into a P-bit parity word and presents it
// on a valid/ready output; flags blocks whose in_last marker disagrees with the beat count.
module gf2_parity_accumulator #(
    parameter int unsigned K = 16,
    parameter int unsigned P = 8
) (
    input logic                           clk,
    input logic                           rst_n,
    input logic                           clr,
    gf2_parity_accumulator_if.slave       bus
);
    localparam int unsigned CntW = (K > 2) ? $clog2(K) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

    logic [P-1:0]    acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [P-1:0]    out_reg_q, out_reg_d;
    logic            out_valid_q, out_valid_d;
    logic            len_err_q, len_err_d;

    logic accept;
    logic last_beat;
    logic consume;

    // Output register may only be refilled once its current word is gone or leaving now.
    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_parity = out_reg_q;
    assign bus.len_err    = len_err_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_beat = (cnt_q == CntLast);
    assign consume   = out_valid_q && bus.out_ready;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_reg_d   = out_reg_q;
        out_valid_d = out_valid_q;
        len_err_d   = 1'b0;

        if (clr) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_reg_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            if (consume) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                len_err_d = (bus.in_last != last_beat);
                if (last_beat) begin
                    out_reg_d   = acc_q ^ bus.in_prod;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = acc_q ^ bus.in_prod;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_reg_q   <= '0;
            out_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_reg_q   <= out_reg_d;
            out_valid_q <= out_valid_d;
            len_err_q   <= len_err_d;
        end
    end
endmodule

// File: doc/gf2_parity_accumulator.md
# gf2_parity_accumulator

Downstream consumer of the GF(2) multiply stage array: each Multi_0_stage cell ANDs a message bit with one generator-matrix entry, and this block takes the P resulting product bits per message bit. It XOR-accumulates K product vectors, one per message bit, into a P-bit parity word. It then presents the word on a valid/ready output, which makes it the accumulate stage of the systematic encoder datapath.

## Interface
- K, default 16: message bits (input beats) per codeword block; K ≥ 2.
- P, default 8: parity width; one product bit per generator column.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush of the block in progress and of the output register.
- in_valid  input  1  product vector present.
- in_ready  output  1  block can accept a beat.
- in_prod  input  P  product vector for the current message bit: bit j = s0 AND f for column j.
- in_last  input  1  upstream marks the final message bit of the block.
- out_valid  output  1  parity word available.
- out_ready  input  1  consumer takes the parity word.
- out_parity  output  P  completed parity word.
- len_err  output  1  one-cycle pulse when in_last disagrees with the internal beat count.

## Operation
- State: acc[P-1:0], cnt with width clog2(K) counting 0..K-1, out_reg[P-1:0], out_valid flag, len_err flag.
- in_ready = !out_valid | out_ready. This is combinational. The output register is never overwritten while it holds an unconsumed word.
- An input beat is accepted when in_valid & in_ready.
- Accept with cnt < K-1:
  - acc ← acc ^ in_prod.
  - cnt ← cnt+1.
- Accept with cnt == K-1:
  - out_reg ← acc ^ in_prod.
  - out_valid ← 1.
  - acc ← 0.
  - cnt ← 0.
- Output handshake: when out_valid & out_ready, the word is consumed. out_valid ← 0 unless a block completes in the same cycle, in which case out_valid stays 1 with the new word.
- Block length is governed only by cnt. in_last does not open or close a block.
- len_err fires on an accepted beat when in_last ≠ (cnt == K-1). It goes high on the next cycle for exactly one cycle, and the beat is still processed normally.
- clr = 1 takes priority over everything except rst_n:
  - acc, cnt, out_valid and len_err ← 0.
  - Any beat presented in that cycle is discarded.
- All arithmetic is XOR (GF(2)). There are no carries and there is no width growth.

## Timing
- Reset values: in_ready = 1 (derived), out_valid = 0, out_parity = 0, len_err = 0. Internally acc = 0 and cnt = 0.
- Asserting rst_n low mid-block clears every register immediately. The partial accumulation is lost, and the first beat after release starts a new block at cnt = 0.
- Latency: out_valid rises on the clock edge after the K-th accepted beat.
- Throughput: one beat per cycle while out_ready is held high. Consecutive blocks run back-to-back with no bubble.
- Backpressure: while out_valid = 1 and out_ready = 0, in_ready = 0. acc, cnt and out_parity stay frozen, and out_parity stays stable until consumed.
- Simultaneous final-beat accept and output consume: the old word leaves and the new word loads on the same edge.
- in_prod and in_last are sampled only on accepted beats. Their values when in_valid = 0 are ignored.
- cnt wrap: after K-1, cnt returns to 0 and never reaches K.

## Test plan
Parameters for all scenarios: K = 4, P = 8.

- **Basic block.** Send beats 0x81, 0x42, 0x24, 0x18 with in_last on beat 4 and out_ready = 1 → out_valid high for 1 cycle, 1 cycle after beat 4, with out_parity = 0xFF. len_err stays 0.
- **Cancellation and back-to-back blocks.** Send block A as 0x5A, 0x5A, 0x0F, 0x00, then block B as 0x01, 0x02, 0x04, 0x08 with no gap → parity 0x0F, then 0x0F again one cycle after B completes. in_ready stays 1 throughout.
- **Backpressure.** Hold out_ready = 0 after block A completes and present B's first beat → in_ready = 0 and out_parity stays 0x0F until out_ready rises. B's beat is accepted on the edge where A's word is consumed, and B's result is correct.
- **Length error.** Assert in_last on beat 2 of a block → len_err pulses 1 cycle after beat 2. The block still closes after beat 4 with the correct XOR of all 4 beats. Omitting in_last on beat 4 also produces a pulse.
- **Flush and reset mid-block.**
  - After 2 beats, pulse clr → the next 4 beats 0x11, 0x22, 0x44, 0x88 give 0xFF with no contamination.
  - Repeat with rst_n pulsed low asynchronously between clock edges → same result, and out_valid = 0 during reset.
- **Zero and identity vectors.** Send 4 beats of 0x00 → 0x00. Send 0xFF, 0xFF, 0xFF, 0x00 → 0xFF.
